// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: core writeback has priority, aux gets a forced slot after MAX_WAIT refusals.
// Optional post-reset zero sweep of every register is enabled by defining RF_CLEAR_EN.
module rf_write_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_reg,
    input  logic [DATA_W-1:0] aux_data,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              init_done
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              stall_q, stall_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
`ifdef RF_CLEAR_EN
    logic [ADDR_W-1:0] idx_q, idx_d;
`endif

    logic wb_hs;
    logic aux_hs;

    // Readies never look at aux_valid, so a requester may derive aux_valid from aux_ready without a loop.
    assign wb_ready  = (state_q == RUN) && !stall_q;
    assign aux_ready = (state_q == RUN) && (stall_q || !wb_valid);
    assign wb_hs     = wb_valid && wb_ready;
    assign aux_hs    = aux_valid && aux_ready;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        stall_d = stall_q;
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        done_d  = done_q;
`ifdef RF_CLEAR_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            CLEAR: begin
`ifdef RF_CLEAR_EN
                we_d    = 1'b1;
                wreg_d  = idx_q;
                wdata_d = '0;
                idx_d   = idx_q + 1'b1;
                if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
`else
                state_d = RUN;
                done_d  = 1'b1;
`endif
            end
            RUN: begin
                // x0 is hardwired: the handshake completes but the write is suppressed.
                if (wb_hs) begin
                    we_d    = |wb_reg;
                    wreg_d  = wb_reg;
                    wdata_d = wb_data;
                end else if (aux_hs) begin
                    we_d    = |aux_reg;
                    wreg_d  = aux_reg;
                    wdata_d = aux_data;
                end

                if (!aux_valid || aux_hs) begin
                    wait_d  = '0;
                    stall_d = 1'b0;
                end else begin
                    if (wait_q < WAIT_MAX) begin
                        wait_d = wait_q + 1'b1;
                    end
                    if (wait_d == WAIT_MAX) begin
                        stall_d = 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= CLEAR;
            wait_q  <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
`ifdef RF_CLEAR_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
`ifdef RF_CLEAR_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign write_enable = we_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;
    assign init_done    = done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: the driver queues expected register-file writes, a negedge monitor pops and compares them.
// Clear-sweep expectations follow RF_CLEAR_EN the same way the design does.
module tb_rf_write_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              aux_valid;
    logic              aux_ready;
    logic [ADDR_W-1:0] aux_reg;
    logic [DATA_W-1:0] aux_data;
    logic              write_enable;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              init_done;

    always #5 CLK = ~CLK;

    rf_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_reg(aux_reg), .aux_data(aux_data),
        .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
        .init_done(init_done)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] rf[32];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic wr_t mk(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        return w;
    endfunction

    // Register-file model and write monitor: capture on the falling edge, as the real file does.
    always @(negedge CLK) begin
        if (write_enable === 1'b1) begin
            wr_t e;
            rf[write_reg] = write_data;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got reg %0d data %h, expected no write", write_reg, write_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_reg", 32'(write_reg), 32'(e.r));
                check("wr_data", write_data, e.d);
            end
        end
    end

    // One request cycle, called at posedge+1; readies are checked before the edge.
    task automatic cycle(input logic wbv, input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                         input logic auxv, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                         input logic exp_wbr, input logic exp_auxr, input string tag);
        wb_valid  = wbv;
        wb_reg    = wr;
        wb_data   = wd;
        aux_valid = auxv;
        aux_reg   = ar;
        aux_data  = ad;
        #2;
        check({tag, "_wb_ready"}, 32'(wb_ready), 32'(exp_wbr));
        check({tag, "_aux_ready"}, 32'(aux_ready), 32'(exp_auxr));
        if (wbv && exp_wbr) begin
            if (wr != 0) exp_q.push_back(mk(wr, wd));
        end else if (auxv && exp_auxr) begin
            if (ar != 0) exp_q.push_back(mk(ar, ad));
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int a;
        RST_N     = 1'b0;
        wb_valid  = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        aux_valid = 1'b0;
        aux_reg   = '0;
        aux_data  = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_reg", 32'(write_reg), 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_wb_ready", 32'(wb_ready), 32'd0);
        check("rst_aux_ready", 32'(aux_ready), 32'd0);

`ifdef RF_CLEAR_EN
        for (int i = 0; i < 10; i++) exp_q.push_back(mk(ADDR_W'(i), '0));
        RST_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("sweep_idx9_reg", 32'(write_reg), 32'd9);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_we", 32'(write_enable), 32'd0);
        check("midrst_reg", 32'(write_reg), 32'd0);
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(ADDR_W'(i), '0));
        RST_N = 1'b1;
        repeat (31) @(posedge CLK);
        #1;
        check("init_done_edge31", 32'(init_done), 32'd0);
        check("sweep_we_edge31", 32'(write_enable), 32'd1);
        @(posedge CLK);
        #1;
        check("init_done_edge32", 32'(init_done), 32'd1);
        check("sweep_last_reg", 32'(write_reg), 32'd31);
        check("first_grant_wb_ready", 32'(wb_ready), 32'd1);
`else
        RST_N = 1'b1;
        #1;
        check("init_done_before_edge", 32'(init_done), 32'd0);
        @(posedge CLK);
        #1;
        check("init_done_edge1", 32'(init_done), 32'd1);
        check("no_sweep_we", 32'(write_enable), 32'd0);
`endif

        // Core-only write to x5.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "core");
        wb_valid = 1'b0;
        check("core_we", 32'(write_enable), 32'd1);
        check("core_reg", 32'(write_reg), 32'd5);
        @(negedge CLK);
        #1;
        check("core_rf_x5", rf[5], 32'hDEADBEEF);
        check("idle_wb_ready", 32'(wb_ready), 32'd1);
        check("idle_aux_ready", 32'(aux_ready), 32'd1);
        @(posedge CLK);
        #1;
        check("idle_we", 32'(write_enable), 32'd0);
        check("idle_hold_reg", 32'(write_reg), 32'd5);
        check("idle_hold_data", write_data, 32'hDEADBEEF);

        // Aux write to x0 handshakes without a write.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b1, "x0");
        aux_valid = 1'b0;
        check("x0_we", 32'(write_enable), 32'd0);
        check("x0_data_reg", write_data, 32'h1234);

        // Continuous contention: four core grants then one aux slot, twice.
        c = 0;
        a = 0;
        for (int k = 0; k < 10; k++) begin
            logic stall;
            stall = (k == 4) || (k == 9);
            cycle(1'b1, 5'(1 + c), 32'h100 + 32'(c), 1'b1, 5'd7, 32'hAAAA0000 + 32'(a),
                  !stall, stall, "cont");
            if (stall) a++;
            else c++;
        end

        // Aux drops during its stall slot: no write, then the core resumes.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 5'(10 + c), 32'h100 + 32'(c), 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, "pre_drop");
            c++;
        end
        cycle(1'b1, 5'(10 + c), 32'h100 + 32'(c), 1'b0, 5'd9, 32'h99, 1'b0, 1'b1, "drop");
        check("drop_we", 32'(write_enable), 32'd0);
        cycle(1'b1, 5'(10 + c), 32'h100 + 32'(c), 1'b0, 5'd9, 32'h99, 1'b1, 1'b0, "resume");

        wb_valid  = 1'b0;
        aux_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("rf_x7_aux", rf[7], 32'hAAAA0001);
`ifdef RF_CLEAR_EN
        check("rf_x0_zero", rf[0], 32'd0);
        check("rf_x31_zero", rf[31], 32'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Single-write-port arbiter and initialisation sequencer for the 32×32 register file. Shares the register file's one write port between the core writeback path and an auxiliary requester (load/debug unit) using valid/ready handshakes. Core writeback has fixed priority, with an anti-starvation slot for the aux port. After reset, optionally sweeps all registers to zero before granting any requester.

## Interface

Parameters:
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- DATA_W, 32, write data width
- MAX_WAIT, 4, cycles aux may be refused before a forced aux slot (≥1)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- wb_valid  in  1  core writeback request
- wb_ready  out  1  core request accepted this cycle
- wb_reg  in  ADDR_W  core destination register
- wb_data  in  DATA_W  core write data
- aux_valid  in  1  aux write request
- aux_ready  out  1  aux request accepted this cycle
- aux_reg  in  ADDR_W  aux destination register
- aux_data  in  DATA_W  aux write data
- write_enable  out  1  to register file write enable (registered)
- write_reg  out  ADDR_W  to register file write address (registered)
- write_data  out  DATA_W  to register file write data (registered)
- init_done  out  1  high once the requester grant phase has begun

## Operation

- States: CLEAR, RUN. RST_N low forces CLEAR, idx=0, wait_cnt=0, stall_slot=0.
- Reset values: write_enable=0, write_reg=0, write_data=0, init_done=0. wb_ready=0 and aux_ready=0 whenever state≠RUN.
- CLEAR: each edge with RST_N high registers write_enable=1, write_reg=idx, write_data=0, then idx++. The edge issuing idx=NUM_REGS-1 also sets state=RUN and init_done=1. x0 is included in the sweep.
- RUN grant, combinational:
  - wb_ready = !stall_slot
  - aux_ready = stall_slot | !wb_valid
  - At most one handshake per cycle. In a stall_slot cycle, the core must hold its request.
- On a handshake edge, the winner's reg/data are registered onto the write port. write_enable=1 unless the reg is 0. Writes to x0 complete the handshake but leave write_enable=0.
- No handshake: write_enable=0; write_reg and write_data hold their values.
- Starvation counter:
  - wait_cnt increments on each edge with aux_valid & !aux_ready, saturating at MAX_WAIT.
  - wait_cnt clears on an aux handshake or when aux_valid is low.
  - stall_slot is registered: set when wait_cnt reaches MAX_WAIT; cleared on the aux handshake edge.
  - If aux_valid drops while stall_slot=1, stall_slot clears on the next edge.
- Reset mid-CLEAR or mid-RUN: sweep restarts from idx=0. Any in-flight registered write is dropped (write_enable=0 during reset).

## Timing

- Latency: handshake at edge N → write port valid in cycle N..N+1 → register file captures at the falling edge inside that cycle. A read of the same register before that falling edge returns the old value.
- Throughput: one write per cycle, sustained.
- Clear: write_enable high for exactly NUM_REGS consecutive cycles after reset release. init_done rises on edge NUM_REGS; the first grant is possible in that cycle.
- Worst-case aux wait: MAX_WAIT+1 cycles under continuous core traffic.
- Readies depend combinationally on wb_valid and stall_slot only, never on aux_valid. This avoids combinational loops.

## Configuration

- RF_CLEAR_EN defined: CLEAR sweep as above; init_done at edge 32 after release (default widths).
- RF_CLEAR_EN undefined: no sweep. The first edge after release sets state=RUN and init_done=1; write_enable stays 0 until the first handshake. Register contents are undefined until written.

## Test plan

- Reset release with RF_CLEAR_EN: write_enable=1 for 32 cycles, write_reg 0→31, write_data=0; init_done=1 on edge 32; every register reads 0 afterwards.
- Core only: wb_valid with reg 5, data 0xDEADBEEF → wb_ready=1; next cycle write_enable=1, write_reg=5; RD of x5 returns 0xDEADBEEF after the falling edge.
- x0: aux write reg 0, data 0x1234 → aux_ready=1, write_enable stays 0; x0 reads 0.
- Contention, MAX_WAIT=4: wb_valid and aux_valid held continuously → core granted 4 consecutive cycles, then stall_slot, wb_ready=0, aux granted once; pattern repeats.
- Simultaneous request after stall: aux_valid drops in the stall_slot cycle → no write that cycle; stall_slot clears next edge; core resumes.
- Reset mid-sweep: RST_N low at clear idx=10 for 1 cycle → write_enable=0 during reset; sweep restarts at write_reg=0; init_done after 32 more cycles.
